// File: rtl/pick_csdf_pkg.sv
// Shared helpers for the PICK CSDF sequencer: width math, phase-table entry
// layout {skip, port, lane} and the default (round-robin) table contents.
package pick_csdf_pkg;

    // Ceiling log2 for elaboration-time width calculation.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Field width that never collapses to zero bits.
    function automatic int fld_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Entry layout: lane in the LSBs, port above it, skip flag on top.
    localparam int LANE_LSB = 0;

    function automatic int port_lsb(input int l_w);
        return l_w;
    endfunction

    function automatic int skip_bit(input int p_w, input int l_w);
        return p_w + l_w;
    endfunction

    // Flat FIFO index used for in_empty / in_read / in_data slices.
    function automatic int idx_of(input int lane, input int port, input int ports);
        return lane * ports + port;
    endfunction

    // Range test kept in a function so narrow fields compare cleanly.
    function automatic logic in_range(input int v, input int lim);
        return v < lim;
    endfunction

    // Default entry p: skip=0, port=p%PORTS, lane=(p/PORTS)%FLUX.
    function automatic int def_entry(input int p, input int ports, input int flux,
                                     input int l_w);
        return ((p % ports) << l_w) | ((p / ports) % flux);
    endfunction

endpackage

// File: rtl/pick_csdf_sequencer_table.sv
// Phase table: NUM_PH entries of {skip, port, lane}, synchronous write,
// asynchronous read, reset to the default round-robin schedule.
module pick_phase_table
    import pick_csdf_pkg::*;
#(
    parameter int NUM_PH = 4,
    parameter int PORTS  = 2,
    parameter int FLUX   = 2,
    parameter int PH_W   = 2,
    parameter int P_W    = 1,
    parameter int L_W    = 1,
    parameter int E_W    = 1 + P_W + L_W
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            we,
    input  logic [PH_W-1:0] waddr,
    input  logic [E_W-1:0]  wdata,
    input  logic [PH_W-1:0] raddr,
    output logic [E_W-1:0]  rdata
);

    logic [E_W-1:0] r_tab [NUM_PH];

    // Table storage: reload defaults on reset, otherwise accept in-range writes.
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int p = 0; p < NUM_PH; p++) begin
                r_tab[p] <= E_W'(def_entry(p, PORTS, FLUX, L_W));
            end
        end else if (we && in_range(int'(waddr), NUM_PH)) begin
            r_tab[waddr] <= wdata;
        end
    end

    assign rdata = r_tab[raddr];

endmodule

// File: rtl/pick_csdf_sequencer.sv
// PICK CSDF phase sequencer: each phase selects one (port, lane) FIFO, pops a
// token when it is non-empty and downstream has room, and forwards it one
// cycle later. Skip entries (or out-of-range ones) just advance the phase.
// Handshake: a pop happens in cycle t only when the selected in_empty=0 and
// out_full=0; the popped token appears as a one-cycle out_wr pulse in t+1.
module pick_csdf_sequencer
    import pick_csdf_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int PORTS  = 2,
    parameter int FLUX   = 2,
    parameter int NUM_PH = 4,
    parameter int PH_W   = fld_w(NUM_PH),
    parameter int P_W    = fld_w(PORTS),
    parameter int L_W    = fld_w(FLUX)
) (
    input  logic                        ck,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic                        cfg_we,
    input  logic [PH_W-1:0]             cfg_addr,
    input  logic [P_W+L_W:0]            cfg_data,
    input  logic [PORTS*FLUX-1:0]       in_empty,
    output logic [PORTS*FLUX-1:0]       in_read,
    input  logic [PORTS*FLUX*WIDTH-1:0] in_data,
    input  logic                        out_full,
    output logic                        out_wr,
    output logic [WIDTH-1:0]            out_data,
    output logic [PH_W-1:0]             phase,
    output logic [15:0]                 fire_cnt
);

    localparam int E_W      = 1 + P_W + L_W;
    localparam int N_FIFO   = PORTS * FLUX;
    localparam int IDX_W    = fld_w(N_FIFO);
    localparam int SKIP_BIT = skip_bit(P_W, L_W);
    localparam int PORT_LSB = port_lsb(L_W);

    logic [PH_W-1:0]   r_phase;
    logic [15:0]       r_fire_cnt;
    logic              r_out_wr;
    logic [WIDTH-1:0]  r_out_data;

    logic [E_W-1:0]    w_entry;
    logic [P_W-1:0]    w_port;
    logic [L_W-1:0]    w_lane;
    logic              w_skip;
    logic              w_active;
    logic              w_fire;
    logic              w_advance;
    logic [IDX_W-1:0]  w_idx;
    logic [N_FIFO-1:0] w_read;
    logic [WIDTH-1:0]  w_token;
    logic              w_tab_we;

    // Table writes only while the sequencer is stopped.
    assign w_tab_we = cfg_we & ~en;

    pick_phase_table #(
        .NUM_PH(NUM_PH),
        .PORTS (PORTS),
        .FLUX  (FLUX),
        .PH_W  (PH_W),
        .P_W   (P_W),
        .L_W   (L_W),
        .E_W   (E_W)
    ) u_table (
        .ck   (ck),
        .rst  (rst),
        .we   (w_tab_we),
        .waddr(cfg_addr),
        .wdata(cfg_data),
        .raddr(r_phase),
        .rdata(w_entry)
    );

    // Fire decode for the current phase entry; pop strobe is combinational.
    always_comb begin
        w_lane    = w_entry[LANE_LSB +: L_W];
        w_port    = w_entry[PORT_LSB +: P_W];
        w_skip    = w_entry[SKIP_BIT]
                  | ~in_range(int'(w_port), PORTS)
                  | ~in_range(int'(w_lane), FLUX);
        w_idx     = w_skip ? '0 : IDX_W'(idx_of(int'(w_lane), int'(w_port), PORTS));
        w_active  = en & ~clr & ~rst;
        w_fire    = w_active & ~w_skip & ~in_empty[w_idx] & ~out_full;
        w_advance = w_active & (w_skip | w_fire);
        w_token   = in_data[int'(w_idx)*WIDTH +: WIDTH];
        w_read    = '0;
        if (w_fire) begin
            w_read[w_idx] = 1'b1;
        end
    end

    // Phase counter, output register and fire counter.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_phase    <= '0;
            r_fire_cnt <= '0;
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_out_wr <= w_fire;
            if (w_fire) begin
                r_out_data <= w_token;
            end
            if (clr) begin
                r_phase    <= '0;
                r_fire_cnt <= '0;
            end else begin
                if (w_advance) begin
                    r_phase <= (r_phase == PH_W'(NUM_PH - 1)) ? '0 : r_phase + 1'b1;
                end
                if (w_fire) begin
                    r_fire_cnt <= r_fire_cnt + 16'd1;
                end
            end
        end
    end

    assign in_read  = w_read;
    assign out_wr   = r_out_wr;
    assign out_data = r_out_data;
    assign phase    = r_phase;
    assign fire_cnt = r_fire_cnt;

endmodule
